// File: rtl/jtpopeye_prom_we.sv
// -----------------------------------------------------------------------------
// jtpopeye_prom_we
//
// Splits the byte stream coming from the frame's ROM downloader into two
// destinations:
//   * bytes whose address falls inside [PROM_START, PROM_END] are written
//     straight into one of four on-chip 256-byte PROMs (one-cycle strobe);
//   * all other bytes become byte-masked 16-bit SDRAM write requests that
//     are held until the SDRAM controller acknowledges them.
// A one-entry skid buffer absorbs a byte that arrives while an SDRAM write
// is still outstanding. A byte that cannot be held is dropped and flagged
// through the sticky overflow output. When the download ends, dl_done
// pulses once after every accepted SDRAM write has been committed.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   downloading         ROM download in progress
//   ioctl_addr/data/wr  downloaded byte and its one-cycle strobe
//   prog_addr/data/mask SDRAM word address, byte, active-low byte enables
//   prog_we / prog_ack  SDRAM write request (held) and its done pulse
//   prom_we/addr/data   one-hot PROM write strobe, PROM byte address, byte
//   dl_done             one-cycle pulse: download over, all writes done
//   overflow            sticky: an ioctl byte had to be dropped
// -----------------------------------------------------------------------------
module jtpopeye_prom_we #(
  parameter logic [21:0] PROM_START = 22'h0_F000,
  parameter logic [21:0] PROM_END   = 22'h0_F3FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  input  logic        prog_ack,
  output logic [3:0]  prom_we,
  output logic [7:0]  prom_addr,
  output logic [7:0]  prom_data,
  output logic        dl_done,
  output logic        overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Active-low byte enable for a byte address: odd bytes sit in the high lane.
  function automatic logic [1:0] lane_mask(input logic odd);
    lane_mask = odd ? 2'b01 : 2'b10;
  endfunction

  // One-hot PROM select from the two bank bits of the PROM offset.
  function automatic logic [3:0] prom_sel(input logic [1:0] bank);
    prom_sel = 4'b0001 << bank;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q,     state_d;
  logic        buf_valid_q, buf_valid_d;
  logic [21:0] buf_addr_q,  buf_addr_d;
  logic [7:0]  buf_data_q,  buf_data_d;
  logic [1:0]  buf_mask_q,  buf_mask_d;

  logic [21:0] prog_addr_q, prog_addr_d;
  logic [7:0]  prog_data_q, prog_data_d;
  logic [1:0]  prog_mask_q, prog_mask_d;
  logic        prog_we_q,   prog_we_d;

  logic [3:0]  prom_we_q,   prom_we_d;
  logic [7:0]  prom_addr_q, prom_addr_d;
  logic [7:0]  prom_data_q, prom_data_d;

  logic        dl_prev_q,   dl_prev_d;
  logic        armed_q,     armed_d;
  logic        dl_done_q,   dl_done_d;
  logic        overflow_q,  overflow_d;

  // ---------------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------------
  logic        wr_s;
  logic        in_prom_s;
  logic        sd_wr_s;
  logic [9:0]  prom_off_s;
  logic [21:0] new_addr_s;
  logic [1:0]  new_mask_s;
  logic        dl_rise_s;
  logic        dl_fall_s;
  logic        direct_s;
  logic        drop_s;

  assign wr_s       = ioctl_wr & downloading;
  assign in_prom_s  = (ioctl_addr >= PROM_START) && (ioctl_addr <= PROM_END);
  assign sd_wr_s    = wr_s & ~in_prom_s;
  assign prom_off_s = 10'(ioctl_addr - PROM_START);
  assign new_addr_s = {1'b0, ioctl_addr[21:1]};
  assign new_mask_s = lane_mask(ioctl_addr[0]);
  assign dl_rise_s  = downloading & ~dl_prev_q;
  assign dl_fall_s  = ~downloading & dl_prev_q;

  // PROM path: a single-cycle strobe, address and data follow the strobe.
  always_comb begin
    prom_we_d   = 4'b0000;
    prom_addr_d = prom_addr_q;
    prom_data_d = prom_data_q;
    if (wr_s && in_prom_s) begin
      prom_we_d   = prom_sel(prom_off_s[9:8]);
      prom_addr_d = prom_off_s[7:0];
      prom_data_d = ioctl_data;
    end else begin
      prom_we_d   = 4'b0000;
    end
  end

  // SDRAM write engine: next state, held request and skid buffer.
  always_comb begin
    state_d     = state_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prog_mask_d = prog_mask_q;
    prog_we_d   = prog_we_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    buf_mask_d  = buf_mask_q;
    direct_s    = 1'b0;
    drop_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (buf_valid_q) begin
          // A byte captured during the last GAP cycle is issued first.
          state_d     = ST_WRITE;
          prog_we_d   = 1'b1;
          prog_addr_d = buf_addr_q;
          prog_data_d = buf_data_q;
          prog_mask_d = buf_mask_q;
          buf_valid_d = 1'b0;
        end else if (sd_wr_s) begin
          state_d     = ST_WRITE;
          prog_we_d   = 1'b1;
          prog_addr_d = new_addr_s;
          prog_data_d = ioctl_data;
          prog_mask_d = new_mask_s;
          direct_s    = 1'b1;
        end else begin
          prog_we_d   = 1'b0;
        end
      end
      ST_WRITE: begin
        if (prog_ack) begin
          state_d   = ST_GAP;
          prog_we_d = 1'b0;
        end else begin
          prog_we_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (buf_valid_q) begin
          state_d     = ST_WRITE;
          prog_we_d   = 1'b1;
          prog_addr_d = buf_addr_q;
          prog_data_d = buf_data_q;
          prog_mask_d = buf_mask_q;
          buf_valid_d = 1'b0;
        end else begin
          state_d   = ST_IDLE;
          prog_we_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        prog_we_d = 1'b0;
      end
    endcase

    // A byte not issued directly goes to the skid buffer if it was empty at
    // this edge; a full buffer (even one being drained now) drops the byte.
    if (sd_wr_s && !direct_s) begin
      if (buf_valid_q) begin
        drop_s = 1'b1;
      end else begin
        buf_valid_d = 1'b1;
        buf_addr_d  = new_addr_s;
        buf_data_d  = ioctl_data;
        buf_mask_d  = new_mask_s;
      end
    end else begin
      drop_s = 1'b0;
    end
  end

  // Download bookkeeping: overflow flag and end-of-download completion.
  always_comb begin
    dl_prev_d  = downloading;
    overflow_d = overflow_q;
    armed_d    = armed_q;
    dl_done_d  = 1'b0;

    // A new download starts with a clean flag; a drop in the same cycle wins.
    if (dl_rise_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_d;
    end

    if (dl_fall_s) begin
      armed_d = 1'b1;
    end else if (dl_rise_s) begin
      armed_d = 1'b0;
    end else if (armed_q && (state_q == ST_IDLE) && !buf_valid_q) begin
      dl_done_d = 1'b1;
      armed_d   = 1'b0;
    end else begin
      armed_d   = armed_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= 22'd0;
      buf_data_q  <= 8'd0;
      buf_mask_q  <= 2'b11;
      prog_addr_q <= 22'd0;
      prog_data_q <= 8'd0;
      prog_mask_q <= 2'b11;
      prog_we_q   <= 1'b0;
      prom_we_q   <= 4'b0000;
      prom_addr_q <= 8'd0;
      prom_data_q <= 8'd0;
      dl_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
      dl_done_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      buf_mask_q  <= buf_mask_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_mask_q <= prog_mask_d;
      prog_we_q   <= prog_we_d;
      prom_we_q   <= prom_we_d;
      prom_addr_q <= prom_addr_d;
      prom_data_q <= prom_data_d;
      dl_prev_q   <= dl_prev_d;
      armed_q     <= armed_d;
      dl_done_q   <= dl_done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign prog_addr = prog_addr_q;
  assign prog_data = prog_data_q;
  assign prog_mask = prog_mask_q;
  assign prog_we   = prog_we_q;
  assign prom_we   = prom_we_q;
  assign prom_addr = prom_addr_q;
  assign prom_data = prom_data_q;
  assign dl_done   = dl_done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_jtpopeye_prom_we.sv
// -----------------------------------------------------------------------------
// tb_jtpopeye_prom_we
//
// Directed scenarios followed by random traffic. Every cycle all DUT outputs
// are compared with a behavioural model that tracks the outstanding SDRAM
// write, the gap cycle, a one-entry buffer queue and the download flags.
// -----------------------------------------------------------------------------
module tb_jtpopeye_prom_we;

  localparam logic [21:0] P_START = 22'h0_F000;
  localparam logic [21:0] P_END   = 22'h0_F3FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        downloading = 1'b0;
  logic [21:0] ioctl_addr = 22'd0;
  logic [7:0]  ioctl_data = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic        prog_ack = 1'b0;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic [3:0]  prom_we;
  logic [7:0]  prom_addr;
  logic [7:0]  prom_data;
  logic        dl_done;
  logic        overflow;

  always #5 clk = ~clk;

  jtpopeye_prom_we #(.PROM_START(P_START), .PROM_END(P_END)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .downloading(downloading),
    .ioctl_addr (ioctl_addr),
    .ioctl_data (ioctl_data),
    .ioctl_wr   (ioctl_wr),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_mask  (prog_mask),
    .prog_we    (prog_we),
    .prog_ack   (prog_ack),
    .prom_we    (prom_we),
    .prom_addr  (prom_addr),
    .prom_data  (prom_data),
    .dl_done    (dl_done),
    .overflow   (overflow)
  );

  typedef struct packed {
    logic [21:0] a;
    logic [7:0]  d;
    logic [1:0]  m;
  } wr_t;

  int total = 0;
  int bad   = 0;

  // Behavioural model
  bit         m_busy, m_gap, m_armed, m_done, m_over, m_prev;
  wr_t        m_cur;
  wr_t        m_buf[$];
  logic [3:0] m_pwe;
  logic [7:0] m_paddr, m_pdata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_gap = 1'b0; m_armed = 1'b0; m_done = 1'b0;
    m_over = 1'b0; m_prev = 1'b0;
    m_cur  = '{a: 22'd0, d: 8'd0, m: 2'b11};
    m_buf.delete();
    m_pwe = 4'd0; m_paddr = 8'd0; m_pdata = 8'd0;
  endtask

  task automatic model_edge();
    bit  acc, in_prom, idle0, full0, consumed, drop;
    wr_t nb;
    int  off;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc     = downloading && ioctl_wr;
    in_prom = (ioctl_addr >= P_START) && (ioctl_addr <= P_END);
    off     = int'(ioctl_addr) - int'(P_START);
    if (acc && in_prom) begin
      m_pwe   = 4'(1 << (off / 256));
      m_paddr = 8'(off % 256);
      m_pdata = ioctl_data;
    end else begin
      m_pwe = 4'd0;
    end
    nb.a = 22'(ioctl_addr / 2);
    nb.d = ioctl_data;
    nb.m = (ioctl_addr % 2 == 1) ? 2'b01 : 2'b10;
    idle0    = !m_busy && !m_gap;
    full0    = (m_buf.size() != 0);
    consumed = 1'b0;
    drop     = 1'b0;

    m_done = 1'b0;
    if (m_prev && !downloading) m_armed = 1'b1;
    else if (!m_prev && downloading) m_armed = 1'b0;
    else if (m_armed && idle0 && !full0) begin
      m_done = 1'b1; m_armed = 1'b0;
    end

    if (idle0) begin
      if (full0) begin
        m_cur = m_buf.pop_front(); m_busy = 1'b1;
      end else if (acc && !in_prom) begin
        m_cur = nb; m_busy = 1'b1; consumed = 1'b1;
      end
    end else if (m_busy) begin
      if (prog_ack) begin
        m_busy = 1'b0; m_gap = 1'b1;
      end
    end else begin
      m_gap = 1'b0;
      if (full0) begin
        m_cur = m_buf.pop_front(); m_busy = 1'b1;
      end
    end

    if (acc && !in_prom && !consumed) begin
      if (full0) drop = 1'b1;
      else m_buf.push_back(nb);
    end
    if (!m_prev && downloading) m_over = 1'b0;
    if (drop) m_over = 1'b1;
    m_prev = downloading;
  endtask

  task automatic check_all();
    check_val("prog_we",   32'(prog_we),   32'(m_busy));
    check_val("prog_addr", 32'(prog_addr), 32'(m_cur.a));
    check_val("prog_data", 32'(prog_data), 32'(m_cur.d));
    check_val("prog_mask", 32'(prog_mask), 32'(m_cur.m));
    check_val("prom_we",   32'(prom_we),   32'(m_pwe));
    check_val("prom_addr", 32'(prom_addr), 32'(m_paddr));
    check_val("prom_data", 32'(prom_data), 32'(m_pdata));
    check_val("dl_done",   32'(dl_done),   32'(m_done));
    check_val("overflow",  32'(overflow),  32'(m_over));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cyc(input bit dl, input bit wr, input logic [21:0] a,
                     input logic [7:0] d, input bit ack);
    downloading = dl;
    ioctl_wr    = wr;
    ioctl_addr  = a;
    ioctl_data  = d;
    prog_ack    = ack;
    step();
  endtask

  function automatic logic [21:0] rnd_addr();
    logic [21:0] r;
    case ($urandom_range(0, 7))
      0, 1:    r = P_START + 22'($urandom_range(0, 1023));
      2:       r = P_START - 22'd1;
      3:       r = P_END + 22'd1;
      4:       r = P_END;
      5:       r = P_START;
      default: r = 22'($urandom_range(0, 32'h3F_FFFF));
    endcase
    return r;
  endfunction

  initial begin
    bit dl_r;
    model_reset();
    // asynchronous reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #1 check_all();
    step();
    step();
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 22'd0, 8'd0, 1'b0);

    // single SDRAM byte, odd address, acknowledged on the third cycle
    cyc(1'b1, 1'b1, 22'h00_0005, 8'hA5, 1'b0);
    check_val("r035_we",   32'(prog_we),   32'd1);
    check_val("r035_addr", 32'(prog_addr), 32'h2);
    check_val("r035_mask", 32'(prog_mask), 32'h1);
    check_val("r035_data", 32'(prog_data), 32'hA5);
    cyc(1'b1, 1'b0, 22'd0, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 22'd0, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 22'd0, 8'd0, 1'b1);
    check_val("r035_we_off", 32'(prog_we), 32'd0);
    cyc(1'b1, 1'b0, 22'd0, 8'd0, 1'b0);

    // PROM byte into the second PROM
    cyc(1'b1, 1'b1, 22'h0_F123, 8'h3C, 1'b0);
    check_val("r036_we",   32'(prom_we),   32'h2);
    check_val("r036_addr", 32'(prom_addr), 32'h23);
    check_val("r036_pwe",  32'(prog_we),   32'd0);
    cyc(1'b1, 1'b0, 22'd0, 8'd0, 1'b0);
    check_val("r036_we_off", 32'(prom_we), 32'h0);

    // three back-to-back SDRAM bytes with the ack withheld
    cyc(1'b1, 1'b1, 22'd0, 8'h10, 1'b0);
    cyc(1'b1, 1'b1, 22'd1, 8'h11, 1'b0);
    cyc(1'b1, 1'b1, 22'd2, 8'h12, 1'b0);
    check_val("r037_over", 32'(overflow),  32'd1);
    check_val("r037_hold", 32'(prog_mask), 32'h2);
    cyc(1'b1, 1'b0, 22'd0, 8'd0, 1'b1);
    check_val("r037_gap", 32'(prog_we), 32'd0);
    cyc(1'b1, 1'b0, 22'd0, 8'd0, 1'b0);
    check_val("r037_buf_addr", 32'(prog_addr), 32'h0);
    check_val("r037_buf_mask", 32'(prog_mask), 32'h1);
    check_val("r037_buf_data", 32'(prog_data), 32'h11);
    cyc(1'b1, 1'b0, 22'd0, 8'd0, 1'b1);
    cyc(1'b1, 1'b0, 22'd0, 8'd0, 1'b0);

    // download ends while a write is pending
    cyc(1'b1, 1'b1, 22'h00_1234, 8'h77, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 22'd0, 8'd0, 1'b0);
    cyc(1'b0, 1'b0, 22'd0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 22'd0, 8'd0, 1'b0);

    // reset in the middle of a write
    cyc(1'b1, 1'b1, 22'h00_0040, 8'h5A, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 22'd0, 8'd0, 1'($urandom_range(0, 1)));

    // writes ignored when not downloading
    cyc(1'b0, 1'b1, 22'h00_0100, 8'h01, 1'b0);
    cyc(1'b0, 1'b1, 22'h0_F300, 8'h02, 1'b0);
    cyc(1'b0, 1'b0, 22'd0, 8'd0, 1'b0);

    // random traffic
    dl_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) dl_r = ~dl_r;
      cyc(dl_r, 1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 9) < 3));
    end

    // drain
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 22'd0, 8'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
